// File: rtl/riscv_defines.sv
// ---------------------------------------------------------------------------
// riscv_defines
// Shared type definitions for the core's memory-side blocks.
//
// Contents:
//    arb_owner_e  - which requester owns the transaction on the shared port
//    arb_state_e  - phase of the single outstanding memory transaction
//    BE_WIDTH     - byte-enable width of the 32-bit data path
// ---------------------------------------------------------------------------
package riscv_defines;

   localparam int BE_WIDTH = 4;

   // Owner of the transaction currently held by the arbiter. OWN_IF is the
   // reset value, so an aborted transaction never looks like a data access.
   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_LSU = 1'b1
   } arb_owner_e;

   // IDLE: free to arbitrate. REQ: request presented, waiting for the memory
   // to accept it. WAIT: accepted, waiting for the response beat.
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_WAIT = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between the instruction fetch unit (IF) and the
// load/store unit (LSU). Only one transaction is ever in flight: it is
// captured in IDLE, presented in REQ until the memory grants it, and
// finished in WAIT when the response beat arrives (writes included).
//
// Parameters:
//    MEM_ADDR_WIDTH - memory byte address width
//    DATA_WIDTH     - data width
//    LSU_MAX        - consecutive LSU wins allowed while IF is waiting
//
// Ports:
//    clk, rst_n                  - clock, asynchronous active-low reset
//    if_req_i / if_addr_i        - fetch request, held until if_gnt_o
//    if_gnt_o / if_rvalid_o /
//    if_rdata_o                  - fetch grant pulse, response, read data
//    lsu_req_i / lsu_we_i /
//    lsu_be_i / lsu_addr_i /
//    lsu_wdata_i                 - data access request, held until lsu_gnt_o
//    lsu_gnt_o / lsu_rvalid_o /
//    lsu_rdata_o                 - data grant pulse, response, read data
//    mem_req_o / mem_addr_o /
//    mem_we_o / mem_be_o /
//    mem_wdata_o                 - shared memory port request
//    mem_gnt_i / mem_rvalid_i /
//    mem_rdata_i                 - memory grant, response valid, read data
//    if_stall_o / ex_stall_o     - stall requests to pipeline control
//    protocol_err_o              - pulse on a response nobody is waiting for
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import riscv_defines::*;
#(
   parameter int MEM_ADDR_WIDTH = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int LSU_MAX        = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,

   input  logic                      if_req_i,
   input  logic [MEM_ADDR_WIDTH-1:0] if_addr_i,
   output logic                      if_gnt_o,
   output logic                      if_rvalid_o,
   output logic [DATA_WIDTH-1:0]     if_rdata_o,

   input  logic                      lsu_req_i,
   input  logic                      lsu_we_i,
   input  logic [BE_WIDTH-1:0]       lsu_be_i,
   input  logic [MEM_ADDR_WIDTH-1:0] lsu_addr_i,
   input  logic [DATA_WIDTH-1:0]     lsu_wdata_i,
   output logic                      lsu_gnt_o,
   output logic                      lsu_rvalid_o,
   output logic [DATA_WIDTH-1:0]     lsu_rdata_o,

   output logic                      mem_req_o,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
   output logic                      mem_we_o,
   output logic [BE_WIDTH-1:0]       mem_be_o,
   output logic [DATA_WIDTH-1:0]     mem_wdata_o,
   input  logic                      mem_gnt_i,
   input  logic                      mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]     mem_rdata_i,

   output logic                      if_stall_o,
   output logic                      ex_stall_o,
   output logic                      protocol_err_o
);

   // Counter just wide enough to hold LSU_MAX; kept at least one bit wide
   // so a degenerate LSU_MAX of 0 still elaborates.
   localparam int STARVE_W = (LSU_MAX > 0) ? $clog2(LSU_MAX + 1) : 1;
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(LSU_MAX);
   localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

   arb_state_e                state_q, state_d;
   arb_owner_e                owner_q, owner_d;
   logic [STARVE_W-1:0]       starve_q, starve_d;
   logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                      we_q, we_d;
   logic [BE_WIDTH-1:0]       be_q, be_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic                      lsu_wins;
   logic                      fsm_busy;

   // Arbitration decision. The LSU normally has priority because a stalled
   // data access blocks the whole pipeline, but once it has beaten a waiting
   // fetch LSU_MAX times in a row the fetch is let through.
   always_comb begin
      lsu_wins = lsu_req_i && !(if_req_i && (starve_q == STARVE_MAX));
   end

   // State and captured-request registers. The captured fields are what the
   // memory port shows while in REQ, so requesters may change their inputs
   // as soon as they have been granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ARB_IDLE;
         owner_q  <= OWN_IF;
         starve_q <= '0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         be_q     <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
      end
   end

   // Next-state logic and all outputs. Grants and responses are routed to
   // the current owner combinationally so neither side loses a cycle, and
   // everything not explicitly driven in a state stays at zero.
   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      starve_d       = starve_q;
      addr_d         = addr_q;
      we_d           = we_q;
      be_d           = be_q;
      wdata_d        = wdata_q;

      if_gnt_o       = 1'b0;
      if_rvalid_o    = 1'b0;
      if_rdata_o     = '0;
      lsu_gnt_o      = 1'b0;
      lsu_rvalid_o   = 1'b0;
      lsu_rdata_o    = '0;
      mem_req_o      = 1'b0;
      mem_addr_o     = '0;
      mem_we_o       = 1'b0;
      mem_be_o       = '0;
      mem_wdata_o    = '0;
      protocol_err_o = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            // Nothing is outstanding, so any response here is stray.
            protocol_err_o = mem_rvalid_i;
            if (lsu_wins) begin
               state_d = ARB_REQ;
               owner_d = OWN_LSU;
               addr_d  = lsu_addr_i;
               we_d    = lsu_we_i;
               be_d    = lsu_be_i;
               wdata_d = lsu_wdata_i;
               // Only a fetch that is actually waiting accumulates starvation.
               if (if_req_i) begin
                  if (starve_q != STARVE_MAX) begin
                     starve_d = starve_q + STARVE_ONE;
                  end
               end else begin
                  starve_d = '0;
               end
            end else if (if_req_i) begin
               // Fetches are read-only, so the write fields are cleared.
               state_d  = ARB_REQ;
               owner_d  = OWN_IF;
               addr_d   = if_addr_i;
               we_d     = 1'b0;
               be_d     = '0;
               wdata_d  = '0;
               starve_d = '0;
            end else begin
               starve_d = '0;
            end
         end

         ARB_REQ: begin
            mem_req_o      = 1'b1;
            mem_addr_o     = addr_q;
            mem_we_o       = we_q;
            mem_be_o       = be_q;
            mem_wdata_o    = wdata_q;
            protocol_err_o = mem_rvalid_i;
            if (mem_gnt_i) begin
               state_d = ARB_WAIT;
               if (owner_q == OWN_LSU) begin
                  lsu_gnt_o = 1'b1;
               end else begin
                  if_gnt_o = 1'b1;
               end
            end
         end

         ARB_WAIT: begin
            if (mem_rvalid_i) begin
               state_d = ARB_IDLE;
               if (owner_q == OWN_LSU) begin
                  lsu_rvalid_o = 1'b1;
                  lsu_rdata_o  = mem_rdata_i;
               end else begin
                  if_rvalid_o = 1'b1;
                  if_rdata_o  = mem_rdata_i;
               end
            end
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // Stall requests. The execute stage is also held while its own access is
   // still in flight, released in the very cycle the response arrives.
   always_comb begin
      fsm_busy   = (state_q != ARB_IDLE);
      if_stall_o = if_req_i && !if_gnt_o;
      ex_stall_o = (lsu_req_i && !lsu_gnt_o) ||
                   ((owner_q == OWN_LSU) && fsm_busy && !mem_rvalid_i);
   end

endmodule
